// File: rtl/enemy_ship_mover.sv
// Per-ship movement and firing engine: integrates scheduler step deltas into a
// clamped position, tracks the ship life cycle and raises req/ack fire requests.
module enemy_ship_mover #(
  parameter int NM          = 20,
  parameter int X_MIN       = 0,
  parameter int X_MAX       = 608,
  parameter int Y_MIN       = 0,
  parameter int Y_MAX       = 448,
  parameter int SHIP_W      = 32,
  parameter int SHIP_H      = 32,
  parameter int EXPL_CYCLES = 16
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [9:0]           ESchedCtr,
  input  logic [NM-1:0][9:0]   StepX,
  input  logic [NM-1:0][9:0]   StepY,
  input  logic [NM-1:0]        FireSlot,
  input  logic [9:0]           InitialX,
  input  logic [9:0]           InitialY,
  input  logic                 Start,
  input  logic                 Hit,
  input  logic                 FireAck,
  output logic [9:0]           PosX,
  output logic [9:0]           PosY,
  output logic                 Alive,
  output logic                 Exploding,
  output logic                 FireReq,
  output logic [9:0]           FireX,
  output logic [9:0]           FireY
);

  localparam int IW = (NM > 1) ? $clog2(NM) : 1;
  localparam int CW = (EXPL_CYCLES > 1) ? $clog2(EXPL_CYCLES) : 1;

  typedef enum logic [1:0] {ST_DEAD, ST_SPAWN, ST_ACTIVE, ST_EXPLODE} state_e;

  state_e          state_q, state_d;
  logic [9:0]      ctr_s_q, ctr_s_d;
  logic [9:0]      ctr_prev_q, ctr_prev_d;
  logic [9:0]      pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [9:0]      fire_x_q, fire_x_d, fire_y_q, fire_y_d;
  logic            fire_req_q, fire_req_d;
  logic            alive_q, alive_d, expl_q, expl_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            step;
  logic [IW-1:0]   idx;

  // Positions are unsigned screen coordinates, so PosX is zero-extended (it can
  // exceed 511); the delta is sign-extended and the sum kept 12 bits wide.
  function automatic logic [9:0] clamp_add(input logic [9:0] pos,
                                           input logic [9:0] delta,
                                           input int lo, input int hi);
    logic signed [11:0] sum;
    sum = $signed({2'b00, pos}) + $signed({{2{delta[9]}}, delta});
    if (int'(sum) < lo)      return 10'(lo);
    else if (int'(sum) > hi) return 10'(hi);
    else                     return sum[9:0];
  endfunction

  // The counter is sampled first, then compared against its previous sample,
  // so a change before edge N acts at edge N+1.
  assign step = (ctr_s_q != ctr_prev_q) && (ctr_s_q < 10'(NM));
  assign idx  = ctr_s_q[IW-1:0];

  always_comb begin
    // NOTE: every _d gets a default first so no path through the case infers a latch.
    state_d    = state_q;
    ctr_s_d    = ESchedCtr;
    ctr_prev_d = ctr_s_q;
    pos_x_d    = pos_x_q;
    pos_y_d    = pos_y_q;
    fire_x_d   = fire_x_q;
    fire_y_d   = fire_y_q;
    fire_req_d = fire_req_q && !FireAck;
    cnt_d      = cnt_q;

    if (Start) begin
      state_d = ST_SPAWN;
    end else begin
      unique case (state_q)
        ST_DEAD: ;
        ST_SPAWN: begin
          pos_x_d    = InitialX;
          pos_y_d    = InitialY;
          fire_req_d = 1'b0;
          state_d    = ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (Hit) begin
            state_d    = ST_EXPLODE;
            cnt_d      = CW'(EXPL_CYCLES - 1);
            fire_req_d = 1'b0;
          end else if (step) begin
            pos_x_d = clamp_add(pos_x_q, StepX[idx], X_MIN, X_MAX);
            pos_y_d = clamp_add(pos_y_q, StepY[idx], Y_MIN, Y_MAX);
            // A slot arriving while a request is outstanding is dropped.
            if (FireSlot[idx] && !fire_req_q) begin
              fire_req_d = 1'b1;
              fire_x_d   = pos_x_q + 10'(SHIP_W / 2);
              fire_y_d   = pos_y_q + 10'(SHIP_H);
            end
          end
        end
        ST_EXPLODE: begin
          if (cnt_q == '0) state_d = ST_DEAD;
          else             cnt_d   = cnt_q - 1'b1;
        end
        default: state_d = ST_DEAD;
      endcase
    end

    alive_d = (state_d == ST_ACTIVE);
    expl_d  = (state_d == ST_EXPLODE);
  end

  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (Reset) begin
      state_q    <= ST_DEAD;
      ctr_s_q    <= '0;
      ctr_prev_q <= '0;
      pos_x_q    <= '0;
      pos_y_q    <= '0;
      fire_x_q   <= '0;
      fire_y_q   <= '0;
      fire_req_q <= 1'b0;
      alive_q    <= 1'b0;
      expl_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      ctr_s_q    <= ctr_s_d;
      ctr_prev_q <= ctr_prev_d;
      pos_x_q    <= pos_x_d;
      pos_y_q    <= pos_y_d;
      fire_x_q   <= fire_x_d;
      fire_y_q   <= fire_y_d;
      fire_req_q <= fire_req_d;
      alive_q    <= alive_d;
      expl_q     <= expl_d;
      cnt_q      <= cnt_d;
    end
  end

  assign PosX      = pos_x_q;
  assign PosY      = pos_y_q;
  assign FireX     = fire_x_q;
  assign FireY     = fire_y_q;
  assign FireReq   = fire_req_q;
  assign Alive     = alive_q;
  assign Exploding = expl_q;

endmodule
